pipe_buffer_skid: RTL and testbench

PIPE_BUFFER_SKID -- requirements
Module: pipe_buffer_skid

---
 rtl/pipe_buffer_skid.sv | 116 +++++++++++
 tb/tb_pipe_buffer_skid.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_buffer_skid.sv
// Two-entry skid buffer: registered o_ready, one-cycle latency, full throughput.
// Optional stall counter on o_stall_cnt when PIPE_BUFFER_STATS_EN is defined.
module pipe_buffer_skid #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  input  logic              i_flush,
  output logic [1:0]        o_state
`ifdef PIPE_BUFFER_STATS_EN
  ,
  output logic [CNT_W-1:0]  o_stall_cnt
`endif
);

  // Handshake: a word moves on any edge where valid and ready are both high;
  // a producer keeps valid and data steady until that edge.
  // State encoding equals buffer occupancy, which o_state reports for debug.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      // Flush only drops occupancy; stored words stay put so o_data holds.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = i_data;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state_d = FULL;
            skid_d  = i_data;
          end else if (out_fire && !in_fire) begin
            state_d = EMPTY;
          end else if (in_fire && out_fire) begin
            main_d = i_data;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    o_valid = (state_q != EMPTY);
    o_ready = (state_q != FULL);
    o_data  = main_q;
    o_state = state_q;
  end

`ifdef PIPE_BUFFER_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_valid && !i_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_buffer_skid.sv
// Bench for pipe_buffer_skid: directed scenarios plus random traffic against a queue model.
module tb_pipe_buffer_skid;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready;
  logic          i_flush;
  logic [1:0]    o_state;
`ifdef PIPE_BUFFER_STATS_EN
  logic [CW-1:0] o_stall_cnt;
`endif

  int checks;
  int failures;

  // Reference model: contents in order, value left on o_data, stall count.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_hold;
  logic [CW-1:0] exp_cnt;

  pipe_buffer_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ready    (i_ready),
    .i_flush    (i_flush),
    .o_state    (o_state)
`ifdef PIPE_BUFFER_STATS_EN
    ,
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("o_valid", o_valid, exp_q.size() > 0);
    check("o_ready", o_ready, exp_q.size() < 2);
    check("o_data", o_data, exp_hold);
    check("occupancy", o_state, exp_q.size());
`ifdef PIPE_BUFFER_STATS_EN
    check("stall_cnt", o_stall_cnt, exp_cnt);
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_hold = '0;
    exp_cnt  = '0;
  endtask

  // Drive one cycle from a negedge, advance the model across the posedge, then compare.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    logic in_f;
    logic out_f;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
    in_f  = v && (exp_q.size() < 2);
    out_f = (exp_q.size() > 0) && r;
    if ((exp_q.size() > 0) && !r && (exp_cnt != {CW{1'b1}})) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    if (f) begin
      exp_q.delete();
    end else begin
      if (out_f) void'(exp_q.pop_front());
      if (in_f) exp_q.push_back(d);
    end
    if (exp_q.size() > 0) exp_hold = exp_q[0];
    #1;
    compare_outputs();
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;
    i_ready  = 1'b0;
    i_flush  = 1'b0;
    model_reset();
    #1;
    check("reset_valid", o_valid, 1'b0);
    check("reset_ready", o_ready, 1'b1);
    check("reset_data", o_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure fills the skid slot
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    check("bp_full_ready", o_ready, 1'b0);
    check("bp_full_data", o_data, 32'hA);
    step(1'b0, '0, 1'b1, 1'b0);
    check("bp_drain1_data", o_data, 32'hB);
    check("bp_drain1_ready", o_ready, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush from FULL with a simultaneous offer
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    check("flush_valid", o_valid, 1'b0);
    check("flush_ready", o_ready, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous accept and drain in ONE
    step(1'b1, 32'h5, 1'b0, 1'b0);
    step(1'b1, 32'h6, 1'b1, 1'b0);
    check("simul_data", o_data, 32'h6);
    check("simul_occ", o_state, 2'd1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Long stall, then flush while stalled
    step(1'b1, 32'h7, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_BUFFER_STATS_EN
    check("stall_sat", o_stall_cnt, 4'hF);
`endif
    step(1'b0, '0, 1'b0, 1'b1);
`ifdef PIPE_BUFFER_STATS_EN
    check("stall_after_flush", o_stall_cnt, 4'hF);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset while holding data
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    rst_n   = 1'b0;
    i_valid = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", o_valid, 1'b0);
    check("async_rst_ready", o_ready, 1'b1);
    check("async_rst_data", o_data, 0);
`ifdef PIPE_BUFFER_STATS_EN
    check("async_rst_cnt", o_stall_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
